// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption core.
//   NR / NB      : round count and state width in 32-bit columns
//   aes_fsm_e    : controller state encoding (exposed for trace/debug binding)
//   xtime        : multiply by x in GF(2^8), reduction polynomial 0x11B
//   gf_mul       : general GF(2^8) multiply built from xtime (XOR-only)
//   mix_column   : MixColumns on one 32-bit column (byte0 in [31:24])
//   shift_src    : ShiftRows source byte index for a destination byte index
//   byte_lsb     : bit position of the LSB of byte idx in a 128-bit state
package aes_pkg;

  localparam int NR = 10;
  localparam int NB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  // Shift left one bit; fold the carried-out x^8 term back in as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Column times the circulant matrix {02 03 01 01}.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Byte idx sits at row idx%4, column idx/4. Row r rotates left by r,
  // so destination (r,c) takes source (r,(c+r)%4).
  function automatic int shift_src(input int idx);
    int r;
    int c;
    r = idx % 4;
    c = idx / 4;
    return 4 * ((c + r) % 4) + r;
  endfunction

  function automatic int byte_lsb(input int idx);
    return 120 - 8 * idx;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round, purely combinational.
//   state_in    : 128-bit state, byte0 = [127:120], column-major
//   rk          : round key for this round
//   final_round : 1 skips MixColumns (round 10)
//   state_out   : AddRoundKey(MixColumns?(ShiftRows(SubBytes(state_in))))
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0]   sub [16];
  logic [127:0] shifted;
  logic [127:0] mixed;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .value       (state_in[byte_lsb(i) +: 8]),
      .substituted (sub[i])
    );
    assign shifted[byte_lsb(i) +: 8] = sub[shift_src(i)];
  end

  for (genvar c = 0; c < NB; c++) begin : g_mix
    assign mixed[96 - 32 * c +: 32] = mix_column(shifted[96 - 32 * c +: 32]);
  end

  assign state_out = (final_round ? shifted : mixed) ^ rk;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational.
//   value       : input byte
//   substituted : S(value)
// The multiplicative inverse is x^254 (x^254 = 0 for x = 0, matching the
// AES definition), built with a short square-and-multiply chain, followed by
// the affine transform b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] substituted
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  assign x2   = gf_mul(value, value);
  assign x3   = gf_mul(x2, value);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign substituted = inv
                     ^ {inv[6:0], inv[7]}
                     ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]}
                     ^ {inv[3:0], inv[7:4]}
                     ^ 8'h63;

endmodule

// File: rtl/aes_encrypt_iter_128.sv
// Iterative AES-128 encryption: one round per clock, 10 rounds per block.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : plaintext handshake (in_ready only in IDLE)
//   plaintext           : 128-bit block, byte0 = [127:120]
//   key_s0..key_s10     : round keys, held stable from accept until DONE
//   out_valid/out_ready : ciphertext handshake (out_valid only in DONE)
//   ciphertext          : state register, stable while out_valid waits
//   round_idx           : round being computed, 0 when not in ROUND
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. valid never depends on ready; ready is a function of FSM state only.
module aes_encrypt_iter_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key_s0,
  input  logic [127:0] key_s1,
  input  logic [127:0] key_s2,
  input  logic [127:0] key_s3,
  input  logic [127:0] key_s4,
  input  logic [127:0] key_s5,
  input  logic [127:0] key_s6,
  input  logic [127:0] key_s7,
  input  logic [127:0] key_s8,
  input  logic [127:0] key_s9,
  input  logic [127:0] key_s10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic [3:0]   round_idx
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] round_keys [16];
  logic [127:0] rk_sel;
  logic [127:0] round_out;
  logic         final_round;

  // Padded to 16 entries so every counter value selects something defined.
  always_comb begin
    for (int i = 0; i < 16; i++) round_keys[i] = '0;
    round_keys[0]  = key_s0;
    round_keys[1]  = key_s1;
    round_keys[2]  = key_s2;
    round_keys[3]  = key_s3;
    round_keys[4]  = key_s4;
    round_keys[5]  = key_s5;
    round_keys[6]  = key_s6;
    round_keys[7]  = key_s7;
    round_keys[8]  = key_s8;
    round_keys[9]  = key_s9;
    round_keys[10] = key_s10;
  end

  assign rk_sel      = round_keys[round_q];
  assign final_round = (round_q == 4'(NR));

  aes_round u_round (
    .state_in    (state_q),
    .rk          (rk_sel),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = plaintext ^ key_s0;
          round_d = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        // The counter advances regardless of key contents, so a key change
        // mid-block corrupts the result but never stalls the FSM.
        if (final_round) begin
          round_d = 4'd0;
          fsm_d   = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d   = ST_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  assign ciphertext = state_q;
  assign round_idx  = round_q;

endmodule

// File: tb/tb_aes_encrypt_iter_128.sv
module tb_aes_encrypt_iter_128;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic [3:0]   round_idx;
  logic [127:0] rk [0:10];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [127:0] exp_q[$];
  int acc_q[$];
  bit prev_ov = 1'b0;

  aes_encrypt_iter_128 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_s0     (rk[0]),
    .key_s1     (rk[1]),
    .key_s2     (rk[2]),
    .key_s3     (rk[3]),
    .key_s4     (rk[4]),
    .key_s5     (rk[5]),
    .key_s6     (rk[6]),
    .key_s7     (rk[7]),
    .key_s8     (rk[8]),
    .key_s9     (rk[9]),
    .key_s10    (rk[10]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .round_idx  (round_idx)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream key-expansion model, so the bench can feed the round-key ports.
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = tb_gmul(inv, x);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  // Leaves in_valid high on return; the caller decides when to drop it.
  task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit expect_out);
    int n;
    n = 0;
    in_valid  = 1'b1;
    plaintext = pt;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 128'(in_ready), 128'd1);
    last_acc = cyc + 1;
    if (expect_out) begin
      exp_q.push_back(ct);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(out_valid), 128'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Samples just after the negedge, once the driver has settled the inputs
  // that the next rising edge will see.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (round_idx != 4'd0)
        check("round_idx", 128'(round_idx), 128'(cyc - last_acc + 1));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 128'(out_valid), 128'd0);
        end else begin
          if (!prev_ov) check("latency", 128'(cyc - acc_q[0]), 128'd10);
          if (out_ready) begin
            check("ciphertext", ciphertext, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
    end
    prev_ov = out_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    int a1;
    int a2;
    int hs;
    int n;
    expand_key(KEY_B);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    plaintext = PT_B;
    out_ready = 1'b1;

    // Reset held with in_valid high: nothing accepted, nothing produced.
    repeat (4) begin
      @(negedge clk);
      check("rst_hold_out_valid", 128'(out_valid), 128'd0);
      check("rst_hold_round_idx", 128'(round_idx), 128'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_ciphertext", ciphertext, 128'd0);
    check("rst_round_idx", 128'(round_idx), 128'd0);
    @(negedge clk);

    // App.B and App.C.1 with out_ready high.
    send(PT_B, CT_B, 1'b1);
    in_valid = 1'b0;
    drain("drain_app_b");
    expand_key(KEY_C);
    send(PT_C, CT_C, 1'b1);
    in_valid = 1'b0;
    drain("drain_app_c");

    // Backpressure: hold out_ready low in DONE, offer another block meanwhile.
    out_ready = 1'b0;
    expand_key(KEY_B);
    send(PT_B, CT_B, 1'b1);
    in_valid = 1'b0;
    wait_out_valid("bp_done");
    in_valid  = 1'b1;
    plaintext = PT_C;
    expand_key(KEY_C);
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ciphertext", ciphertext, CT_B);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    out_ready = 1'b0;
    send(PT_C, CT_C, 1'b1);
    check("bp_next_accept", 128'(last_acc), 128'(hs + 1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("drain_bp");

    // Back-to-back: in_valid and out_ready held high, keys swapped once DONE.
    expand_key(KEY_B);
    send(PT_B, CT_B, 1'b1);
    a1 = last_acc;
    plaintext = PT_C;
    wait_out_valid("b2b_first_done");
    expand_key(KEY_C);
    send(PT_C, CT_C, 1'b1);
    a2 = last_acc;
    check("b2b_spacing", 128'(a2 - a1), 128'd12);
    in_valid = 1'b0;
    drain("drain_b2b");

    // Reset in the middle of round 5, then a fresh block.
    expand_key(KEY_B);
    send(PT_B, 128'd0, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (round_idx !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_round5", 128'(round_idx), 128'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_ciphertext", ciphertext, 128'd0);
    check("mid_rst_round_idx", 128'(round_idx), 128'd0);
    send(PT_B, CT_B, 1'b1);
    in_valid = 1'b0;
    drain("drain_after_reset");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
